// File: rtl/sign_truncator_if.sv
// Handshake bundle for the sign truncator: upstream word channel, downstream
// result channel and the overflow counter controls.
interface sign_truncator_if #(
  parameter int sizeOut = 9
);

  // Upstream channel
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in;

  // Downstream channel
  logic               out_valid;
  logic               out_ready;
  logic [sizeOut-1:0] out;
  logic               fits;

  // Overflow statistics
  logic [7:0]         ovf_count;
  logic               clear_count;

  // Producer/consumer side (drives words in, accepts results).
  modport master (
    output in_valid, in, out_ready, clear_count,
    input  in_ready, out_valid, out, fits, ovf_count
  );

  // Truncator side.
  modport slave (
    input  in_valid, in, out_ready, clear_count,
    output in_ready, out_valid, out, fits, ovf_count
  );

endinterface

// File: rtl/sign_truncator.sv
// Narrows a signed 64-bit word to a sizeOut-bit signed field, saturating when
// the value does not fit. Two-stage valid/ready pipeline with full throughput
// and a sticky-at-255 counter of delivered overflows.
module sign_truncator #(
  parameter int sizeOut = 9
) (
  input  logic            clk,
  input  logic            reset,
  sign_truncator_if.slave bus
);

  if (sizeOut < 2 || sizeOut > 63) begin : g_bad_size
    $error("sign_truncator: sizeOut must be within 2..63");
  end

  localparam logic [sizeOut-1:0] MaxPos = {1'b0, {(sizeOut-1){1'b1}}};
  localparam logic [sizeOut-1:0] MinNeg = {1'b1, {(sizeOut-1){1'b0}}};

  // Fit test and saturation of the incoming word
  logic signed [63:0]  shifted;
  logic                fits_c;
  logic [sizeOut-1:0]  res_c;

  // Stage registers
  logic                rdy_q,      rdy_d;
  logic                s1_valid_q, s1_valid_d;
  logic [sizeOut-1:0]  s1_data_q,  s1_data_d;
  logic                s1_fits_q,  s1_fits_d;
  logic                s2_valid_q, s2_valid_d;
  logic [sizeOut-1:0]  s2_data_q,  s2_data_d;
  logic                s2_fits_q,  s2_fits_d;
  logic [7:0]          cnt_q,      cnt_d;

  // Handshake terms
  logic                s2_fire;
  logic                s2_load;
  logic                in_ready_c;
  logic                in_fire;

  // Compute fit flag and narrowed/saturated value for the word on the input.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    res_c   = bus.in[sizeOut-1:0];
    // The word fits iff bits [63:sizeOut-1] are all copies of the sign bit,
    // i.e. the arithmetic shift leaves all zeros or all ones.
    shifted = $signed(bus.in) >>> (sizeOut - 1);
    fits_c  = (shifted == 64'sd0) || (shifted == -64'sd1);
    if (!fits_c) begin
      res_c = bus.in[63] ? MinNeg : MaxPos;
    end
  end

  // Pipeline advance, input acceptance and overflow count next-state.
  always_comb begin
    s2_fire    = s2_valid_q & bus.out_ready;
    s2_load    = s1_valid_q & (~s2_valid_q | bus.out_ready);
    // rdy_q keeps in_ready low while reset is held and until the first edge.
    in_ready_c = rdy_q & (~s1_valid_q | s2_load);
    in_fire    = bus.in_valid & in_ready_c;

    rdy_d      = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_fits_d  = s1_fits_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_fits_d  = s2_fits_q;
    cnt_d      = cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = res_c;
      s1_fits_d  = fits_c;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q;
      s2_fits_d  = s1_fits_q;
    end else if (s2_fire) begin
      s2_valid_d = 1'b0;
    end

    // Clear takes priority over a same-cycle overflow delivery.
    if (bus.clear_count) begin
      cnt_d = 8'd0;
    end else if (s2_fire && !s2_fits_q && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State register; reset empties both stages and zeroes visible outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_fits_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_fits_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      rdy_q      <= rdy_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_fits_q  <= s1_fits_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_fits_q  <= s2_fits_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out       = s2_data_q;
  assign bus.fits      = s2_fits_q;
  assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_sign_truncator.sv
// Self-checking bench for sign_truncator (sizeOut = 9): directed scenarios
// with literal expectations plus randomized traffic against an arithmetic
// reference model and an in-order result queue.
module tb_sign_truncator;

  localparam int SIZE = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sign_truncator_if #(.sizeOut(SIZE)) bus ();

  sign_truncator #(.sizeOut(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [SIZE-1:0] out;
    logic            fits;
  } res_t;

  int   n_total = 0;
  int   n_pass  = 0;

  res_t exp_q[$];
  res_t got_log[$];
  int   got_cyc[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   model_cnt = 0;
  bit   stall_prev = 1'b0;
  res_t stall_val;
  bit   armed;
  res_t cmp_e;
  bit   cmp_deliv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: representable range of a SIZE-bit signed field, clamp otherwise.
  function automatic res_t model(input logic [63:0] v);
    longint sv;
    longint maxv;
    longint minv;
    res_t   r;
    sv     = v;
    maxv   = (longint'(1) <<< (SIZE - 1)) - 1;
    minv   = -maxv - 1;
    r.fits = (sv >= minv) && (sv <= maxv);
    if (r.fits)      r.out = SIZE'(sv);
    else if (sv < 0) r.out = SIZE'(minv);
    else             r.out = SIZE'(maxv);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // Compare process: sampled on the falling edge, between driving edges.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
    end else begin
      cyc++;
      check("ovf_count", 64'(bus.ovf_count), 64'(model_cnt));
      if (armed)
        check("in_ready", 64'(bus.in_ready), 64'((exp_q.size() < 2) || bus.out_ready));
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_hold", 64'({bus.out, bus.fits}), 64'(stall_val));
      end
      cmp_deliv = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", bus.out);
        end else begin
          cmp_e = exp_q.pop_front();
          check("out", 64'(bus.out), 64'(cmp_e.out));
          check("fits", 64'(bus.fits), 64'(cmp_e.fits));
          cmp_deliv = 1'b1;
          got_log.push_back({bus.out, bus.fits});
          got_cyc.push_back(cyc);
        end
      end
      if (bus.clear_count) model_cnt = 0;
      else if (cmp_deliv && !cmp_e.fits && model_cnt < 255) model_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in));
        acc_cyc.push_back(cyc);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = {bus.out, bus.fits};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v);
    bus.in_valid = 1'b1;
    bus.in       = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_total++;
    $display("FAIL send_timeout: got no in_ready expected acceptance of 0x%0h", v);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    n_total++;
    $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
  endtask

  function automatic logic [63:0] pick_word();
    logic [63:0] edges [6];
    edges[0] = 64'd255;
    edges[1] = 64'd256;
    edges[2] = 64'hFFFF_FFFF_FFFF_FF00;
    edges[3] = 64'hFFFF_FFFF_FFFF_FEFF;
    edges[4] = 64'd0;
    edges[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    case ($urandom_range(0, 4))
      0:       return 64'(longint'($urandom_range(0, 511)) - 256);
      1:       return edges[$urandom_range(0, 5)];
      2:       return {$urandom, $urandom};
      3:       return ($urandom_range(0, 1) != 0) ? 64'(longint'(256 + $urandom_range(0, 1000)))
                                                  : 64'(-longint'(257 + $urandom_range(0, 1000)));
      default: return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  int   base;
  int   abase;
  int   acc;
  res_t r;
  logic [63:0] w35 [3];

  initial begin
    bus.in_valid    = 1'b0;
    bus.in          = '0;
    bus.out_ready   = 1'b1;
    bus.clear_count = 1'b0;
    reset           = 1'b1;

    // Outputs while reset is held
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_fits", 64'(bus.fits), 64'd0);
    check("rst_ovf", 64'(bus.ovf_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Pin the reference model with hand-computed values
    r = model(64'hFFFF_FFFF_FFFF_FF00);
    check("model_m256", 64'(r), 64'({9'h100, 1'b1}));
    r = model(64'h100);
    check("model_256", 64'(r), 64'({9'h0FF, 1'b0}));
    r = model(64'hFFFF_FFFF_FFFF_FEFF);
    check("model_m257", 64'(r), 64'({9'h100, 1'b0}));
    r = model(64'hFF);
    check("model_255", 64'(r), 64'({9'h0FF, 1'b1}));

    // -256 fits exactly; latency of two cycles
    base  = got_log.size();
    abase = acc_cyc.size();
    send(64'hFFFF_FFFF_FFFF_FF00);
    drain();
    check("m256_result", 64'(got_log[base]), 64'({9'h100, 1'b1}));
    check("m256_latency", 64'(got_cyc[base] - acc_cyc[abase]), 64'd2);
    check("m256_ovf", 64'(bus.ovf_count), 64'd0);

    // Positive and negative saturation
    base = got_log.size();
    send(64'h100);
    send(64'hFFFF_FFFF_FFFF_FEFF);
    drain();
    check("sat_pos", 64'(got_log[base]), 64'({9'h0FF, 1'b0}));
    check("sat_neg", 64'(got_log[base+1]), 64'({9'h100, 1'b0}));
    check("sat_ovf", 64'(bus.ovf_count), 64'd2);

    // Back-to-back words exit on consecutive cycles
    base = got_log.size();
    send(64'h0);
    send(64'hFF);
    send(64'h1FF);
    drain();
    check("b2b_0", 64'(got_log[base]), 64'({9'h000, 1'b1}));
    check("b2b_1", 64'(got_log[base+1]), 64'({9'h0FF, 1'b1}));
    check("b2b_2", 64'(got_log[base+2]), 64'({9'h0FF, 1'b0}));
    check("b2b_gap01", 64'(got_cyc[base+1] - got_cyc[base]), 64'd1);
    check("b2b_gap12", 64'(got_cyc[base+2] - got_cyc[base+1]), 64'd1);

    // Downstream stall: only two words fit, then release drains in order
    w35[0] = 64'h5;
    w35[1] = 64'h1000;
    w35[2] = 64'hFFFF_FFFF_FFFF_F000;
    base = got_log.size();
    acc  = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in       = w35[(acc > 2) ? 2 : acc];
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    send(w35[2]);
    drain();
    check("stall_w0", 64'(got_log[base]), 64'({9'h005, 1'b1}));
    check("stall_w1", 64'(got_log[base+1]), 64'({9'h0FF, 1'b0}));
    check("stall_w2", 64'(got_log[base+2]), 64'({9'h100, 1'b0}));
    check("stall_same_cycle_accept", 64'(acc_cyc[acc_cyc.size()-1]), 64'(got_cyc[base]));
    check("stall_gap01", 64'(got_cyc[base+1] - got_cyc[base]), 64'd1);
    check("stall_gap12", 64'(got_cyc[base+2] - got_cyc[base+1]), 64'd1);

    // Counter saturation, then clear racing an overflow delivery
    bus.clear_count = 1'b1;
    tick();
    bus.clear_count = 1'b0;
    for (int k = 0; k < 300; k++)
      send((k % 2 == 0) ? 64'h1_0000 : 64'hFFFF_FFFF_FFFF_0000);
    drain();
    check("ovf_saturated", 64'(bus.ovf_count), 64'd255);
    bus.out_ready = 1'b0;
    send(64'h2_0000);
    repeat (3) tick();
    bus.out_ready   = 1'b1;
    bus.clear_count = 1'b1;
    @(negedge clk);
    check("clear_race_delivering", 64'({bus.out_valid, bus.fits}), 64'b10);
    tick();
    bus.clear_count = 1'b0;
    check("clear_wins", 64'(bus.ovf_count), 64'd0);

    // Reset with both stages full discards in-flight words
    bus.out_ready = 1'b0;
    send(64'h11);
    send(64'h22);
    tick();
    check("prereset_full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_ovf", 64'(bus.ovf_count), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    base = got_log.size();
    repeat (3) tick();
    check("midrst_no_ghost", 64'(got_log.size()), 64'(base));
    send(64'h42);
    drain();
    check("midrst_count", 64'(got_log.size()), 64'(base + 1));
    check("midrst_first", 64'(got_log[base]), 64'({9'h042, 1'b1}));

    // Randomized traffic, checked cycle by cycle by the compare process
    for (int k = 0; k < 1500; k++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in          = pick_word();
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.clear_count = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.in_valid    = 1'b0;
    bus.clear_count = 1'b0;
    bus.out_ready   = 1'b1;
    drain();
    tick();
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
